// File: rtl/axis_pkt_rx_fifo.sv
// AXI-Stream receive endpoint with a store-and-forward packet FIFO.
// Beats are released on a first-word-fall-through read port only after the
// whole packet they belong to has been buffered. Packets longer than MAX_LEN
// are cut at MAX_LEN beats (last beat forced), the rest is dropped, and a
// sticky error flag is raised.
module axis_pkt_rx_fifo #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned MAX_LEN = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [DATA_W-1:0]            s_axis_tdata,
   input  logic                         s_axis_tlast,
   input  logic                         rd_en,
   output logic                         rd_valid,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_last,
   output logic [$clog2(DEPTH+1)-1:0]   pkt_avail,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
   output logic                         len_err,
   input  logic                         err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LastCnt = CW'(MAX_LEN - 1);
   localparam logic [CW-1:0] FullLvl = CW'(DEPTH);

   typedef enum logic [0:0] {StRecv, StDiscard} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   level_q, level_d;
   logic [CW-1:0]   pkt_q, pkt_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
   logic            len_err_q, len_err_d;

   // Each entry holds {last, data}; validity comes only from the pointers.
   logic [DATA_W:0] mem_q [DEPTH];

   logic            full;
   logic            tready;
   logic            accept;
   logic            wr_en;
   logic            wr_last;
   logic            over_len;
   logic            pkt_valid;
   logic            pop;
   logic [DATA_W:0] head;
   logic            head_last;
   logic            pkt_inc;
   logic            pkt_dec;

   assign full      = (level_q == FullLvl);
   assign head      = mem_q[rd_ptr_q];
   assign head_last = head[DATA_W];
   assign pkt_valid = (pkt_q != '0);
   // Complete packets always sit at the head, so any counted packet makes the head poppable.
   assign pop       = rd_en && pkt_valid && !rst;
   assign accept    = s_axis_tvalid && tready;
   assign pkt_inc   = wr_en && wr_last;
   assign pkt_dec   = pop && head_last;

   // Ready depends only on registered state: no combinational path from rd_en.
   always_comb begin
      tready = (state_q == StDiscard) || !full;
      if (rst) begin
         tready = 1'b0;
      end
   end

   // Receive FSM: decides whether an accepted beat is stored, and its last flag.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      wr_en      = 1'b0;
      wr_last    = 1'b0;
      over_len   = 1'b0;
      case (state_q)
         StRecv: begin
            if (accept) begin
               wr_en = 1'b1;
               if (s_axis_tlast) begin
                  wr_last    = 1'b1;
                  beat_cnt_d = '0;
               end else if (beat_cnt_q == LastCnt) begin
                  // Over-long packet: close it here and drop the tail.
                  wr_last    = 1'b1;
                  over_len   = 1'b1;
                  beat_cnt_d = '0;
                  state_d    = StDiscard;
               end else begin
                  beat_cnt_d = beat_cnt_q + CW'(1);
               end
            end
         end
         StDiscard: begin
            if (accept && s_axis_tlast) begin
               state_d = StRecv;
            end
         end
         default: begin
            state_d = StRecv;
         end
      endcase
   end

   // Pointer, level and packet-count bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      pkt_d    = pkt_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
         2'b10:   level_d = level_q + CW'(1);
         2'b01:   level_d = level_q - CW'(1);
         default: level_d = level_q;
      endcase
      case ({pkt_inc, pkt_dec})
         2'b10:   pkt_d = pkt_q + CW'(1);
         2'b01:   pkt_d = pkt_q - CW'(1);
         default: pkt_d = pkt_q;
      endcase
   end

   // Sticky length error: a new over-length event beats a simultaneous clear.
   always_comb begin
      len_err_d = len_err_q;
      if (over_len) begin
         len_err_d = 1'b1;
      end else if (err_clr) begin
         len_err_d = 1'b0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StRecv;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         pkt_q      <= '0;
         beat_cnt_q <= '0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         pkt_q      <= pkt_d;
         beat_cnt_q <= beat_cnt_d;
         len_err_q  <= len_err_d;
      end
   end

   // Storage array write port; no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {wr_last, s_axis_tdata};
      end
   end

   // Read port and status outputs; head data is masked when nothing is releasable.
   always_comb begin
      s_axis_tready = tready;
      rd_valid      = pkt_valid && !rst;
      rd_data       = '0;
      rd_last       = 1'b0;
      if (rd_valid) begin
         rd_data = head[DATA_W-1:0];
         rd_last = head_last;
      end
      pkt_avail  = pkt_q;
      fifo_level = level_q;
      len_err    = len_err_q;
   end

   // Structural invariants of the bookkeeping.
   a_level_bound : assert property (@(posedge clk) disable iff (rst) level_q <= FullLvl);
   a_pkt_le_level : assert property (@(posedge clk) disable iff (rst) pkt_q <= level_q);
   a_no_write_full : assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule
